// File: rtl/h264intra4x4_modesel.sv
// Intra-4x4 mode-decision sequencer: walks 16 sub-blocks, accumulates per-mode SADs, picks and encodes the cheapest mode.
// Define I4X4_PMBIAS_EN to credit PMBIAS against the most-probable mode's cost during the decision.
module h264intra4x4_modesel #(
  parameter int NMODES  = 9,
  parameter int ROWSADW = 10,
  parameter int SADW    = 12,
  parameter int PMBIAS  = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      start,
  input  logic                      lvalid,
  input  logic                      tvalid,
  output logic [3:0]                submb,
  output logic                      blk_go,
  input  logic                      sad_valid,
  input  logic [NMODES*ROWSADW-1:0] sad_in,
  input  logic [3:0]                pred_mode,
  output logic                      mode_valid,
  input  logic                      mode_ready,
  output logic [3:0]                mode_out,
  output logic                      prev_flag,
  output logic [2:0]                rem_mode,
  input  logic                      recon_done,
  output logic                      busy,
  output logic                      mb_done
);

  // state  | meaning
  // IDLE   | waiting for start
  // GO     | blk_go pulse, accumulators cleared
  // ACC    | accumulating 4 rows of per-mode SADs
  // DECIDE | serial min search, one mode per cycle
  // OUT    | decision presented until mode_ready
  // WAIT_R | waiting for reconstruction of current sub-block
  // DONE   | mb_done pulse
  typedef enum logic [2:0] {IDLE, GO, ACC, DECIDE, OUT, WAIT_R, DONE} state_t;

`ifdef I4X4_PMBIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif
  localparam logic [SADW-1:0] BIAS_AMT = SADW'(PMBIAS);

  state_t           state;
  logic [SADW-1:0]  acc [NMODES];
  logic [1:0]       beat;
  logic [3:0]       mcnt;
  logic             have;
  logic [SADW-1:0]  best_cost;
  logic [3:0]       best_mode;

  logic             l_av, t_av, cur_avail, take, enc_flag;
  logic [SADW-1:0]  cur_acc, cur_cost;
  logic [3:0]       next_mode;
  logic [2:0]       enc_rem;

  function automatic logic mode_avail(input logic [3:0] m, input logic l, input logic t);
    case (m)
      4'd0, 4'd3, 4'd7: return t;
      4'd1, 4'd8:       return l;
      4'd2:             return 1'b1;
      4'd4, 4'd5, 4'd6: return l & t;
      default:          return 1'b0;
    endcase
  endfunction

  // Neighbour data inside the MB is always present; only edge sub-blocks depend on lvalid/tvalid.
  assign l_av = lvalid | submb[2] | submb[0];
  assign t_av = tvalid | submb[3] | submb[1];

  always_comb begin
    cur_acc = '0;
    for (int m = 0; m < NMODES; m++)
      if (mcnt == 4'(m)) cur_acc = acc[m];
    cur_avail = mode_avail(mcnt, l_av, t_av);
    cur_cost  = cur_acc;
    if (BIAS_EN && (mcnt == pred_mode))
      cur_cost = (cur_acc > BIAS_AMT) ? cur_acc - BIAS_AMT : '0;
    take      = cur_avail && (!have || (cur_cost < best_cost));
    next_mode = take ? mcnt : best_mode;
    enc_flag  = (next_mode == pred_mode);
    if (enc_flag)                    enc_rem = 3'd0;
    else if (next_mode < pred_mode)  enc_rem = next_mode[2:0];
    else                             enc_rem = 3'(next_mode - 4'd1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      submb      <= '0;
      blk_go     <= 1'b0;
      mode_valid <= 1'b0;
      busy       <= 1'b0;
      mb_done    <= 1'b0;
      mode_out   <= '0;
      prev_flag  <= 1'b0;
      rem_mode   <= '0;
      beat       <= '0;
      mcnt       <= '0;
      have       <= 1'b0;
      best_cost  <= '0;
      best_mode  <= '0;
      for (int m = 0; m < NMODES; m++) acc[m] <= '0;
    end else begin
      blk_go  <= 1'b0;
      mb_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          submb  <= '0;
          busy   <= 1'b1;
          blk_go <= 1'b1;
          state  <= GO;
        end
        GO: begin
          for (int m = 0; m < NMODES; m++) acc[m] <= '0;
          beat  <= '0;
          state <= ACC;
        end
        ACC: if (sad_valid) begin
          for (int m = 0; m < NMODES; m++)
            acc[m] <= acc[m] + SADW'(sad_in[m*ROWSADW +: ROWSADW]);
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            mcnt  <= '0;
            have  <= 1'b0;
            state <= DECIDE;
          end
        end
        DECIDE: begin
          if (take) begin
            best_cost <= cur_cost;
            best_mode <= mcnt;
            have      <= 1'b1;
          end
          mcnt <= mcnt + 4'd1;
          if (mcnt == 4'(NMODES-1)) begin
            mode_out   <= next_mode;
            prev_flag  <= enc_flag;
            rem_mode   <= enc_rem;
            mode_valid <= 1'b1;
            state      <= OUT;
          end
        end
        OUT: if (mode_ready) begin
          mode_valid <= 1'b0;
          state      <= WAIT_R;
        end
        WAIT_R: if (recon_done) begin
          if (submb == 4'd15) begin
            busy    <= 1'b0;
            mb_done <= 1'b1;
            state   <= DONE;
          end else begin
            submb  <= submb + 4'd1;
            blk_go <= 1'b1;
            state  <= GO;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_h264intra4x4_modesel.sv
// Directed bench for h264intra4x4_modesel: a 9-mode instance for full MBs and a 3-mode instance for the reduced set.
module tb_h264intra4x4_modesel;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic        start_a, lvalid, tvalid, sad_valid_a, mode_ready_a, recon_a;
  logic [89:0] sad_a;
  logic [3:0]  pred_a, submb_a, mode_out_a;
  logic        blk_go_a, mode_valid_a, prev_flag_a, busy_a, mb_done_a;
  logic [2:0]  rem_a;

  logic        start_b, sad_valid_b, mode_ready_b, recon_b;
  logic [29:0] sad_b;
  logic [3:0]  pred_b, submb_b, mode_out_b;
  logic        blk_go_b, mode_valid_b, prev_flag_b, busy_b, mb_done_b;
  logic [2:0]  rem_b;

  int n_assert = 0;
  int n_fail   = 0;
  int last_lat;

  h264intra4x4_modesel dut_a (
    .CLK(CLK), .RESET(RESET), .start(start_a), .lvalid(lvalid), .tvalid(tvalid),
    .submb(submb_a), .blk_go(blk_go_a), .sad_valid(sad_valid_a), .sad_in(sad_a),
    .pred_mode(pred_a), .mode_valid(mode_valid_a), .mode_ready(mode_ready_a),
    .mode_out(mode_out_a), .prev_flag(prev_flag_a), .rem_mode(rem_a),
    .recon_done(recon_a), .busy(busy_a), .mb_done(mb_done_a)
  );

  h264intra4x4_modesel #(.NMODES(3)) dut_b (
    .CLK(CLK), .RESET(RESET), .start(start_b), .lvalid(1'b1), .tvalid(1'b1),
    .submb(submb_b), .blk_go(blk_go_b), .sad_valid(sad_valid_b), .sad_in(sad_b),
    .pred_mode(pred_b), .mode_valid(mode_valid_b), .mode_ready(mode_ready_b),
    .mode_out(mode_out_b), .prev_flag(prev_flag_b), .rem_mode(rem_b),
    .recon_done(recon_b), .busy(busy_b), .mb_done(mb_done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every mode gets row value base except mode sm which gets sv.
  task automatic feed_a(input int base, input int sm, input int sv, input int pm);
    int cnt = 0;
    while (!blk_go_a && cnt < 200) begin @(negedge CLK); cnt++; end
    check("blk_go_a_seen", blk_go_a, 1);
    pred_a = 4'(pm);
    for (int m = 0; m < 9; m++) sad_a[m*10 +: 10] = (m == sm) ? 10'(sv) : 10'(base);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin @(negedge CLK); cnt++; sad_valid_a = 1'b1; end
    @(negedge CLK); cnt++; sad_valid_a = 1'b0;
    while (!mode_valid_a && cnt < 100) begin @(negedge CLK); cnt++; end
    check("mode_valid_a_seen", mode_valid_a, 1);
    last_lat = cnt;
  endtask

  task automatic finish_a();
    mode_ready_a = 1'b1;
    @(negedge CLK);
    mode_ready_a = 1'b0;
    check("a_valid_drop_after_hs", mode_valid_a, 0);
    recon_a = 1'b1;
    @(negedge CLK);
    recon_a = 1'b0;
  endtask

  task automatic check_dec_a(input string tag, input int m, input int f, input int r);
    check({tag, "_mode"}, mode_out_a, m);
    check({tag, "_flag"}, prev_flag_a, f);
    check({tag, "_rem"},  rem_a, r);
  endtask

  initial begin
    int em, cnt;
    logic xx, yy;
    RESET = 1'b1;
    start_a = 0; lvalid = 0; tvalid = 0; sad_valid_a = 0; mode_ready_a = 0; recon_a = 0;
    sad_a = '0; pred_a = 0;
    start_b = 0; sad_valid_b = 0; mode_ready_b = 0; recon_b = 0; sad_b = '0; pred_b = 0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check("rst_submb", submb_a, 0);
    check("rst_blk_go", blk_go_a, 0);
    check("rst_mode_valid", mode_valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_mb_done", mb_done_a, 0);
    check("rst_mode_out", mode_out_a, 0);

    // MB1: no neighbours, flat SADs; availability alone decides (ties go to the lowest index).
    start_a = 1'b1; @(negedge CLK); start_a = 1'b0;
    check("mb1_busy", busy_a, 1);
    for (int b = 0; b < 16; b++) begin
      feed_a(10, 0, 10, 2);
      check("mb1_submb", submb_a, b);
      xx = b[2] | b[0];
      yy = b[3] | b[1];
`ifdef I4X4_PMBIAS_EN
      em = 2;
`else
      em = yy ? 0 : (xx ? 1 : 2);
`endif
      if (b == 0) check("mb1_latency", last_lat, 14);
      check_dec_a("mb1", em, (em == 2) ? 1 : 0, (em == 2) ? 0 : em);
      finish_a();
    end
    check("mb1_done_pulse", mb_done_a, 1);
    check("mb1_busy_low", busy_a, 0);
    @(negedge CLK);
    check("mb1_done_one_cycle", mb_done_a, 0);

    // MB2: both neighbours available.
    lvalid = 1'b1; tvalid = 1'b1;
    start_a = 1'b1; @(negedge CLK); start_a = 1'b0;
    feed_a(5, 0, 1, 2);
    check_dec_a("v_cheap", 0, 0, 0);
    finish_a();

    feed_a(7, 0, 7, 4);
`ifdef I4X4_PMBIAS_EN
    check_dec_a("tie_bias", 4, 1, 0);
`else
    check_dec_a("tie", 0, 0, 0);
`endif
    finish_a();

    // Held decision: stalled consumer, stray start and stray recon_done.
    feed_a(3, 5, 0, 7);
    check_dec_a("hold_init", 5, 0, 5);
    for (int i = 0; i < 20; i++) begin
      start_a = (i == 5);
      recon_a = (i == 10);
      check("hold_valid", mode_valid_a, 1);
      check("hold_mode", mode_out_a, 5);
      check("hold_rem", rem_a, 5);
      check("hold_submb", submb_a, 2);
      @(negedge CLK);
    end
    start_a = 1'b0; recon_a = 1'b0;
    check("hold_busy", busy_a, 1);
    check("hold_submb_after", submb_a, 2);
    finish_a();

    for (int b = 3; b < 7; b++) begin
      feed_a(4, 1, 1, 1);
      check("mb2_submb", submb_a, b);
      check_dec_a("h_pred", 1, 1, 0);
      finish_a();
    end

    // Abort in ACC of sub-block 7.
    cnt = 0;
    while (!blk_go_a && cnt < 200) begin @(negedge CLK); cnt++; end
    check("abort_blk_go", blk_go_a, 1);
    check("abort_submb7", submb_a, 7);
    @(negedge CLK); sad_valid_a = 1'b1;
    @(negedge CLK);
    @(negedge CLK); sad_valid_a = 1'b0; RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    check("abort_submb", submb_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_valid", mode_valid_a, 0);
    check("abort_blk_go_low", blk_go_a, 0);
    check("abort_mode_out", mode_out_a, 0);
    check("abort_flag", prev_flag_a, 0);
    check("abort_rem", rem_a, 0);
    check("abort_mb_done", mb_done_a, 0);
    start_a = 1'b1; @(negedge CLK); start_a = 1'b0;
    check("restart_blk_go", blk_go_a, 1);
    check("restart_submb", submb_a, 0);
    check("restart_busy", busy_a, 1);
    feed_a(6, 2, 0, 2);
    check_dec_a("restart_dc", 2, 1, 0);
    RESET = 1'b1; @(negedge CLK); RESET = 1'b0;

    // Three-mode instance: V=3, H=2, DC=5 per row.
    start_b = 1'b1; @(negedge CLK); start_b = 1'b0;
    cnt = 0;
    while (!blk_go_b && cnt < 200) begin @(negedge CLK); cnt++; end
    check("b_blk_go", blk_go_b, 1);
    pred_b = 4'd2;
    sad_b = {10'd5, 10'd2, 10'd3};
    cnt = 0;
    for (int i = 0; i < 4; i++) begin @(negedge CLK); cnt++; sad_valid_b = 1'b1; end
    @(negedge CLK); cnt++; sad_valid_b = 1'b0;
    while (!mode_valid_b && cnt < 100) begin @(negedge CLK); cnt++; end
    check("b_valid", mode_valid_b, 1);
    check("b_latency", cnt, 8);
    check("b_mode", mode_out_b, 1);
    check("b_flag", prev_flag_b, 0);
    check("b_rem", rem_b, 1);
    mode_ready_b = 1'b1; @(negedge CLK); mode_ready_b = 1'b0;
    check("b_valid_drop", mode_valid_b, 0);
    recon_b = 1'b1; @(negedge CLK); recon_b = 1'b0;
    check("b_submb_next", submb_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
